// File: rtl/fir_pkg.sv
// Shared constants, coefficient table, dequantizer and FSM states for the
// decimating FIR stage of the FM demod chain.
package fir_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int TAPS       = 32;
    localparam int QUANT_BITS = 10;

    // Q10 signed low-pass taps, symmetric about the centre.
    localparam logic signed [DATA_WIDTH-1:0] FIR_COEFFS [TAPS] = '{
        -2, -3, -4, -5, -4,  0,  6,  3,
        14, 22, 34, 48, 62, 74, 82, 86,
        86, 82, 74, 62, 48, 34, 22, 14,
         3,  6,  0, -4, -5, -4, -3, -2
    };

    typedef enum logic [1:0] {
        S_FILL,
        S_MAC,
        S_WRITE
    } fir_state_t;

    // Arithmetic shift rounds toward -inf, then truncate to sample width.
    function automatic logic signed [DATA_WIDTH-1:0] dequantize(
        input logic signed [2*DATA_WIDTH-1:0] p
    );
        logic signed [2*DATA_WIDTH-1:0] s;
        s = p >>> QUANT_BITS;
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered multiply followed by dequantize-and-accumulate; the accumulator
// wraps on overflow.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] coeff,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] product;
    logic                 product_vld;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            product     <= '0;
            product_vld <= 1'b0;
            acc         <= '0;
        end else begin
            product     <= PW'(coeff) * PW'(sample);
            product_vld <= enable;
            if (product_vld) begin
                acc <= acc + dequantize(product);
            end
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Decimating FIR: gathers DECIM samples from the FWFT input FIFO, runs one
// tap per cycle through the MAC unit, then pushes the result downstream.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int DECIM = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         in_rd_en,
    input  logic                         in_empty,
    input  logic signed [DATA_WIDTH-1:0] in_dout,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic signed [DATA_WIDTH-1:0] out_din
);

    localparam int CW = $clog2(TAPS + 1);
    localparam int IW = $clog2(TAPS);

    fir_state_t                   state;
    logic signed [DATA_WIDTH-1:0] x [TAPS];
    logic [CW-1:0]                fill_cnt;
    logic [CW-1:0]                tap_idx;
    logic [IW-1:0]                tap_sel;
    logic                         mac_en;
    logic                         mac_clr;
    logic signed [DATA_WIDTH-1:0] mac_coeff;
    logic signed [DATA_WIDTH-1:0] mac_sample;

    // Handshakes are gated by reset so an in-flight frame never writes.
    assign in_rd_en  = !reset && (state == S_FILL)  && !in_empty;
    assign out_wr_en = !reset && (state == S_WRITE) && !out_full;

    assign tap_sel    = tap_idx[IW-1:0];
    assign mac_en     = (state == S_MAC) && (tap_idx != CW'(TAPS));
    assign mac_clr    = out_wr_en;
    assign mac_coeff  = FIR_COEFFS[tap_sel];
    assign mac_sample = x[tap_sel];

    fir_mac_unit u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (mac_clr),
        .enable (mac_en),
        .coeff  (mac_coeff),
        .sample (mac_sample),
        .acc    (out_din)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FILL;
            fill_cnt <= '0;
            tap_idx  <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (state)
                S_FILL: begin
                    if (in_rd_en) begin
                        x[0] <= in_dout;
                        for (int unsigned i = 1; i < TAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        if (fill_cnt == CW'(DECIM - 1)) begin
                            fill_cnt <= '0;
                            tap_idx  <= '0;
                            state    <= S_MAC;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    // Index TAPS is a drain cycle for the multiply pipeline register.
                    if (tap_idx == CW'(TAPS)) begin
                        state <= S_WRITE;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!out_full) begin
                        state <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Randomized bench for fir_decimator against a direct-convolution reference.
module tb_fir_decimator;
    import fir_pkg::*;

    localparam int DECIM = 8;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         in_rd_en;
    logic                         in_empty = 1'b1;
    logic signed [DATA_WIDTH-1:0] in_dout = '0;
    logic                         out_wr_en;
    logic                         out_full = 1'b0;
    logic signed [DATA_WIDTH-1:0] out_din;

    fir_decimator #(.DECIM(DECIM)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int stim_q[$];
    int src_q[$];
    int got_q[$];
    int ref_q[$];
    int gap_pct   = 0;
    bit hold_full = 1'b0;
    int pops      = 0;
    int both_hi   = 0;
    int rd_empty  = 0;
    int wr_full   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // y[k] = sum_i dequant(h[i] * s[DECIM*(k+1)-1-i]), samples before 0 are zero.
    function automatic int model_y(input int k);
        int     n;
        int     acc;
        longint p;
        acc = 0;
        n   = DECIM * (k + 1) - 1;
        for (int i = 0; i < TAPS; i++) begin
            if (n - i >= 0) begin
                p   = longint'(FIR_COEFFS[i]) * longint'(stim_q[n-i]);
                acc += int'(p >>> QUANT_BITS);
            end
        end
        return acc;
    endfunction

    task automatic step();
        @(negedge clock);
        in_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
        if (src_q.size() != 0) in_dout = src_q[0];
        else                   in_dout = $urandom;
        out_full = hold_full;
        #1;
        if (in_rd_en && out_wr_en) both_hi++;
        if (in_rd_en && in_empty)  rd_empty++;
        if (out_wr_en && out_full) wr_full++;
        if (in_rd_en) begin
            void'(src_q.pop_front());
            pops++;
        end
        if (out_wr_en) got_q.push_back(int'(out_din));
    endtask

    task automatic apply_reset();
        src_q.delete();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        pops = 0;
        got_q.delete();
    endtask

    task automatic run_stream(input string tag, input int n_exp);
        int cyc;
        cyc = 0;
        src_q = stim_q;
        got_q.delete();
        while (cyc < 100 * n_exp + 400 && !(src_q.size() == 0 && got_q.size() >= n_exp)) begin
            step();
            cyc++;
        end
        repeat (60) step();
        check_val({tag, "_count"}, got_q.size(), n_exp);
    endtask

    task automatic check_vs_model(input string tag);
        for (int k = 0; k < got_q.size() && k < stim_q.size() / DECIM; k++) begin
            check_val($sformatf("%s_y%0d", tag, k), got_q[k], model_y(k));
        end
    endtask

    initial begin
        int coeff_sum;
        int held;
        int changes;
        int stall_rd;
        int stall_wr;
        int cyc;

        // Reset state
        repeat (3) step();
        check_val("rst_out_din", out_din, 0);
        check_val("rst_wr_en", out_wr_en, 0);
        check_val("rst_rd_en", in_rd_en, 0);
        reset = 1'b0;
        step();
        check_val("post_rst_out_din", out_din, 0);
        check_val("post_rst_wr_en", out_wr_en, 0);

        // Impulse
        apply_reset();
        stim_q.delete();
        stim_q.push_back(1024);
        repeat (63) stim_q.push_back(0);
        run_stream("impulse", 8);
        for (int k = 0; k < 8 && k < got_q.size(); k++)
            check_val($sformatf("impulse_y%0d", k), got_q[k],
                      (k < 4) ? longint'(FIR_COEFFS[8*k+7]) : 0);

        // DC
        apply_reset();
        stim_q.delete();
        repeat (64) stim_q.push_back(1024);
        run_stream("dc", 8);
        check_vs_model("dc");
        coeff_sum = 0;
        for (int i = 0; i < TAPS; i++) coeff_sum += int'(FIR_COEFFS[i]);
        for (int k = 3; k < 8 && k < got_q.size(); k++)
            check_val($sformatf("dc_sum_y%0d", k), got_q[k], coeff_sum);

        // Negative impulse: rounding toward -inf
        apply_reset();
        stim_q.delete();
        stim_q.push_back(-1);
        repeat (63) stim_q.push_back(0);
        run_stream("neg", 8);
        if (got_q.size() > 0) check_val("neg_round_y0", got_q[0], -1);
        check_vs_model("neg");

        // Random samples, no gaps, then 50% starvation on the same data
        stim_q.delete();
        repeat (256) begin
            if ($urandom_range(1) == 1) stim_q.push_back(int'($urandom));
            else                        stim_q.push_back(int'($urandom_range(4095)) - 2048);
        end
        apply_reset();
        gap_pct = 0;
        run_stream("rand", 32);
        check_vs_model("rand");
        ref_q = got_q;
        apply_reset();
        gap_pct = 50;
        run_stream("starve", 32);
        for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
            check_val($sformatf("starve_y%0d", k), got_q[k], ref_q[k]);
        gap_pct = 0;

        // Back-pressure: full held while the first frame reaches the write state
        apply_reset();
        stim_q.delete();
        repeat (16) stim_q.push_back(int'($urandom_range(65535)) - 32768);
        src_q = stim_q;
        hold_full = 1'b1;
        cyc = 0;
        while (pops < DECIM && cyc < 200) begin
            step();
            cyc++;
        end
        check_val("bp_first_frame_pops", pops, DECIM);
        repeat (TAPS + 6) step();
        held = int'(out_din);
        changes = 0;
        stall_rd = 0;
        stall_wr = 0;
        repeat (20) begin
            step();
            if (int'(out_din) != held) changes++;
            if (in_rd_en) stall_rd++;
            if (out_wr_en) stall_wr++;
        end
        check_val("bp_hold_value", held, model_y(0));
        check_val("bp_dout_changes", changes, 0);
        check_val("bp_rd_during_stall", stall_rd, 0);
        check_val("bp_wr_during_stall", stall_wr, 0);
        hold_full = 1'b0;
        got_q.delete();
        cyc = 0;
        while (!(src_q.size() == 0 && got_q.size() >= 2) && cyc < 400) begin
            step();
            cyc++;
        end
        repeat (60) step();
        check_val("bp_count", got_q.size(), 2);
        check_vs_model("bp");

        // Reset in the middle of the MAC phase
        apply_reset();
        stim_q.delete();
        repeat (8) stim_q.push_back(int'($urandom_range(100000)) + 1);
        src_q = stim_q;
        cyc = 0;
        while (pops < DECIM && cyc < 200) begin
            step();
            cyc++;
        end
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check_val("midmac_wr_after_rst", out_wr_en, 0);
        repeat (TAPS + 20) step();
        check_val("midmac_no_write", got_q.size(), 0);
        stim_q.delete();
        stim_q.push_back(1024);
        repeat (63) stim_q.push_back(0);
        run_stream("midmac_impulse", 8);
        for (int k = 0; k < 8 && k < got_q.size(); k++)
            check_val($sformatf("midmac_impulse_y%0d", k), got_q[k],
                      (k < 4) ? longint'(FIR_COEFFS[8*k+7]) : 0);

        // Handshake invariants gathered over the whole run
        check_val("rd_and_wr_same_cycle", both_hi, 0);
        check_val("rd_while_empty", rd_empty, 0);
        check_val("wr_while_full", wr_full, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
